combat_sequencer: RTL and testbench

//  Per-player attack sequencer and hit referee for the two-fighter game.

---
 rtl/combat_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_combat_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/combat_sequencer.sv
// Two-player attack sequencer and hit referee; all state advances on frame_tick.
// Optional build macro CHIP_DAMAGE_EN: dodged hits still deal 1 hp and pulse hit.
module combat_sequencer #(
  parameter int unsigned HP_INIT    = 100,
  parameter int unsigned KICK_DMG   = 10,
  parameter int unsigned FIGHT_DMG  = 5,
  parameter int unsigned WINDUP_FR  = 4,
  parameter int unsigned ACTIVE_FR  = 3,
  parameter int unsigned RECOVER_FR = 6,
  parameter int unsigned KNOCK_FR   = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       p1_kick_req,
  input  logic       p1_fight_req,
  input  logic       p2_kick_req,
  input  logic       p2_fight_req,
  input  logic       p1_dodge,
  input  logic       p2_dodge,
  input  logic       near_x,
  input  logic       near_y,
  output logic       p1_kick,
  output logic       p1_fight,
  output logic       p2_kick,
  output logic       p2_fight,
  output logic [1:0] back1,
  output logic [1:0] back2,
  output logic [7:0] p1_hp,
  output logic [7:0] p2_hp,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1win,
  output logic       p2win,
  output logic       draw
);

  localparam int unsigned MaxA  = (WINDUP_FR > ACTIVE_FR) ? WINDUP_FR : ACTIVE_FR;
  localparam int unsigned MaxB  = (RECOVER_FR > KNOCK_FR) ? RECOVER_FR : KNOCK_FR;
  localparam int unsigned MaxFr = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CW    = $clog2(MaxFr) + 1;

  if (WINDUP_FR < 1 || ACTIVE_FR < 1 || RECOVER_FR < 1 || KNOCK_FR < 1) begin : g_bad_fr
    $error("combat_sequencer: all *_FR parameters must be >= 1");
  end

  typedef enum logic [2:0] {StIdle, StWindup, StActive, StRecover, StKnock} state_e;

  state_e          state_q [2], state_d [2];
  logic [CW-1:0]   cnt_q   [2], cnt_d   [2];
  logic [CW-1:0]   bcnt_q  [2], bcnt_d  [2];
  logic [1:0]      back_q  [2], back_d  [2];
  logic [7:0]      hp_q    [2], hp_d    [2];
  logic [1:0]      is_kick_q, is_kick_d;
  logic [1:0]      kick_q, kick_d, fight_q, fight_d, hit_q, hit_d;
  logic            p1win_q, p1win_d, p2win_q, p2win_d, draw_q, draw_d;

  logic [1:0]      kreq, freq, dodge, strike;
  logic            a, v, anim, over;
  logic [7:0]      dmg;

  assign kreq  = {p2_kick_req, p1_kick_req};
  assign freq  = {p2_fight_req, p1_fight_req};
  assign dodge = {p2_dodge, p1_dodge};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    back_d    = back_q;
    hp_d      = hp_q;
    is_kick_d = is_kick_q;
    hit_d     = '0;
    kick_d    = '0;
    fight_d   = '0;
    p1win_d   = p1win_q;
    p2win_d   = p2win_q;
    draw_d    = draw_q;
    strike    = '0;
    a         = 1'b0;
    v         = 1'b0;
    anim      = 1'b0;
    dmg       = '0;
    over      = p1win_q | p2win_q | draw_q;

    for (int i = 0; i < 2; i++) begin
      a = 1'(i);
      v = ~a;
      strike[a] = (state_q[a] == StActive) && (cnt_q[a] == CW'(ACTIVE_FR)) &&
                  near_x && near_y && (state_q[v] != StKnock);
    end

    if (frame_tick && !over) begin
      for (int i = 0; i < 2; i++) begin
        a = 1'(i);
        unique case (state_q[a])
          StIdle: begin
            if (back_q[a] == 2'd0 && !dodge[a] && (kreq[a] || freq[a])) begin
              state_d[a]   = StWindup;
              cnt_d[a]     = CW'(WINDUP_FR);
              is_kick_d[a] = kreq[a];
            end
          end
          StWindup: begin
            if (cnt_q[a] == CW'(1)) begin
              state_d[a] = StActive;
              cnt_d[a]   = CW'(ACTIVE_FR);
            end else cnt_d[a] = cnt_q[a] - 1'b1;
          end
          StActive: begin
            if (cnt_q[a] == CW'(1)) begin
              state_d[a] = StRecover;
              cnt_d[a]   = CW'(RECOVER_FR);
            end else cnt_d[a] = cnt_q[a] - 1'b1;
          end
          StRecover: begin
            if (cnt_q[a] == CW'(1)) state_d[a] = StIdle;
            else cnt_d[a] = cnt_q[a] - 1'b1;
          end
          StKnock: ;
          default: state_d[a] = StIdle;
        endcase
        // The back code has its own timer; KNOCK ends when it expires.
        if (back_q[a] != 2'd0) begin
          if (bcnt_q[a] == CW'(1)) begin
            back_d[a] = 2'd0;
            if (state_q[a] == StKnock) state_d[a] = StIdle;
          end else bcnt_d[a] = bcnt_q[a] - 1'b1;
        end
      end

      // Resolution uses pre-tick state, so simultaneous strikes trade.
      for (int i = 0; i < 2; i++) begin
        a = 1'(i);
        v = ~a;
        if (strike[a]) begin
          dmg = is_kick_q[a] ? 8'(KICK_DMG) : 8'(FIGHT_DMG);
          if (!dodge[v]) begin
            hp_d[v]    = (hp_q[v] <= dmg) ? 8'd0 : hp_q[v] - dmg;
            hit_d[v]   = 1'b1;
            back_d[v]  = 2'd2;
            bcnt_d[v]  = CW'(KNOCK_FR);
            state_d[v] = StKnock;
          end else begin
            if (back_q[v] != 2'd2) begin
              back_d[v] = 2'd1;
              bcnt_d[v] = CW'(KNOCK_FR);
            end
`ifdef CHIP_DAMAGE_EN
            hp_d[v]  = (hp_q[v] <= 8'd1) ? 8'd0 : hp_q[v] - 8'd1;
            hit_d[v] = 1'b1;
`endif
          end
        end
      end

      if (hp_d[0] == 8'd0 || hp_d[1] == 8'd0) begin
        if (hp_d[0] == 8'd0 && hp_d[1] == 8'd0) draw_d = 1'b1;
        else if (hp_d[1] == 8'd0) p1win_d = 1'b1;
        else p2win_d = 1'b1;
        state_d = '{StIdle, StIdle};
        cnt_d   = '{default: '0};
        bcnt_d  = '{default: '0};
        back_d  = '{default: 2'd0};
      end
    end

    for (int i = 0; i < 2; i++) begin
      a = 1'(i);
      anim = state_d[a] inside {StWindup, StActive, StRecover};
      kick_d[a]  = anim & is_kick_d[a];
      fight_d[a] = anim & ~is_kick_d[a];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= '{StIdle, StIdle};
      cnt_q     <= '{default: '0};
      bcnt_q    <= '{default: '0};
      back_q    <= '{default: 2'd0};
      hp_q      <= '{default: 8'(HP_INIT)};
      is_kick_q <= '0;
      kick_q    <= '0;
      fight_q   <= '0;
      hit_q     <= '0;
      p1win_q   <= 1'b0;
      p2win_q   <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      back_q    <= back_d;
      hp_q      <= hp_d;
      is_kick_q <= is_kick_d;
      kick_q    <= kick_d;
      fight_q   <= fight_d;
      hit_q     <= hit_d;
      p1win_q   <= p1win_d;
      p2win_q   <= p2win_d;
      draw_q    <= draw_d;
    end
  end

  assign p1_kick  = kick_q[0];
  assign p2_kick  = kick_q[1];
  assign p1_fight = fight_q[0];
  assign p2_fight = fight_q[1];
  assign back1    = back_q[0];
  assign back2    = back_q[1];
  assign p1_hp    = hp_q[0];
  assign p2_hp    = hp_q[1];
  assign p1_hit   = hit_q[0];
  assign p2_hit   = hit_q[1];
  assign p1win    = p1win_q;
  assign p2win    = p2win_q;
  assign draw     = draw_q;

endmodule

// File: tb/tb_combat_sequencer.sv
// Table-driven bench for combat_sequencer with a scoreboard of expected post-step outputs.
module tb_combat_sequencer;

  logic       Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0;
  logic       p1_kick_req = 1'b0, p1_fight_req = 1'b0, p2_kick_req = 1'b0, p2_fight_req = 1'b0;
  logic       p1_dodge = 1'b0, p2_dodge = 1'b0, near_x = 1'b0, near_y = 1'b0;
  logic       p1_kick, p1_fight, p2_kick, p2_fight, p1_hit, p2_hit, p1win, p2win, draw;
  logic [1:0] back1, back2;
  logic [7:0] p1_hp, p2_hp;

  always #5 Clk = ~Clk;

  combat_sequencer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .p1_kick_req(p1_kick_req), .p1_fight_req(p1_fight_req),
    .p2_kick_req(p2_kick_req), .p2_fight_req(p2_fight_req),
    .p1_dodge(p1_dodge), .p2_dodge(p2_dodge), .near_x(near_x), .near_y(near_y),
    .p1_kick(p1_kick), .p1_fight(p1_fight), .p2_kick(p2_kick), .p2_fight(p2_fight),
    .back1(back1), .back2(back2), .p1_hp(p1_hp), .p2_hp(p2_hp),
    .p1_hit(p1_hit), .p2_hit(p2_hit), .p1win(p1win), .p2win(p2win), .draw(draw)
  );

`ifdef CHIP_DAMAGE_EN
  localparam logic [7:0] Chip = 8'd1;
`else
  localparam logic [7:0] Chip = 8'd0;
`endif
  localparam logic [7:0] H = 8'd100;

  // anim = {p1_kick,p1_fight,p2_kick,p2_fight}; back = {back1,back2}; hit = {p1,p2};
  // win = {p1win,p2win,draw}
  typedef struct packed {
    logic [3:0] anim;
    logic [3:0] back;
    logic [7:0] hp1;
    logic [7:0] hp2;
    logic [1:0] hit;
    logic [2:0] win;
  } exp_t;

  // req = {p1k,p1f,p2k,p2f}; dodge = {p1,p2}; near = {x,y}
  typedef struct packed {
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic [1:0] dodge;
    logic [1:0] near;
    exp_t       e;
  } row_t;

  exp_t sb[$];
  row_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   row_id   = 0;
  logic [7:0] hp2m;

  function automatic exp_t mk(input logic [3:0] anim, input logic [3:0] back,
                              input logic [7:0] hp1, input logic [7:0] hp2,
                              input logic [1:0] hit, input logic [2:0] win);
    exp_t e;
    e.anim = anim; e.back = back; e.hp1 = hp1; e.hp2 = hp2; e.hit = hit; e.win = win;
    return e;
  endfunction

  function automatic row_t mkrow(input logic rst, input logic tick, input logic [3:0] req,
                                 input logic [1:0] dodge, input logic [1:0] near, input exp_t e);
    row_t r;
    r.rst = rst; r.tick = tick; r.req = req; r.dodge = dodge; r.near = near; r.e = e;
    return r;
  endfunction

  task automatic add(input logic rst, input logic tick, input logic [3:0] req,
                     input logic [1:0] dodge, input logic [1:0] near, input exp_t e);
    tbl.push_back(mkrow(rst, tick, req, dodge, near, e));
  endtask

  task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h expected %0h", id, nm, act, req);
    end
  endtask

  task automatic apply(input row_t r);
    exp_t e;
    @(negedge Clk);
    {p1_kick_req, p1_fight_req, p2_kick_req, p2_fight_req} = r.req;
    {p1_dodge, p2_dodge} = r.dodge;
    {near_x, near_y}     = r.near;
    sb.push_back(r.e);
    if (r.rst) begin
      Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
    end else if (r.tick) begin
      frame_tick = 1'b1; @(negedge Clk); frame_tick = 1'b0;
    end else begin
      repeat (3) @(negedge Clk);
    end
    e = sb.pop_front();
    chk(row_id, "anim", {4'b0, p1_kick, p1_fight, p2_kick, p2_fight}, {4'b0, e.anim});
    chk(row_id, "back", {4'b0, back1, back2}, {4'b0, e.back});
    chk(row_id, "p1_hp", p1_hp, e.hp1);
    chk(row_id, "p2_hp", p2_hp, e.hp2);
    chk(row_id, "hit", {6'b0, p1_hit, p2_hit}, {6'b0, e.hit});
    chk(row_id, "win", {5'b0, p1win, p2win, draw}, {5'b0, e.win});
    row_id++;
  endtask

  task automatic step(input logic rst, input logic tick, input logic [3:0] req,
                      input logic [1:0] dodge, input logic [1:0] near, input exp_t e);
    apply(mkrow(rst, tick, req, dodge, near, e));
  endtask

  // One p1 attack against an idle, non-dodging p2 in range, tracking p2 hp.
  task automatic p1_attack(input logic kick);
    logic [7:0] dmg = kick ? 8'd10 : 8'd5;
    logic [3:0] an  = kick ? 4'b1000 : 4'b0100;
    step(1'b0, 1'b1, an, 2'b00, 2'b11, mk(an, 4'b0000, H, hp2m, 2'b00, 3'b000));
    repeat (4) step(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(an, 4'b0000, H, hp2m, 2'b00, 3'b000));
    if (hp2m <= dmg) begin
      hp2m = 8'd0;
      step(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b0000, 4'b0000, H, 8'd0, 2'b01, 3'b100));
    end else begin
      hp2m = hp2m - dmg;
      step(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(an, 4'b0010, H, hp2m, 2'b01, 3'b000));
      repeat (7) step(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(an, 4'b0010, H, hp2m, 2'b00, 3'b000));
      step(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b0000, 4'b0000, H, hp2m, 2'b00, 3'b000));
    end
  endtask

  initial begin
    exp_t idle0;
    idle0 = mk(4'b0000, 4'b0000, H, H, 2'b00, 3'b000);

    // Plain kick lands: hit on 5th tick after accept, 8-tick knockback.
    add(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    add(1'b0, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b11, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    for (int k = 1; k <= 4; k++)
      add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b1000, 4'b0010, H, 8'd90, 2'b01, 3'b000));
    add(1'b0, 1'b0, 4'b0000, 2'b00, 2'b11, mk(4'b1000, 4'b0010, H, 8'd90, 2'b00, 3'b000));
    for (int k = 6; k <= 12; k++)
      add(1'b0, 1'b1, (k == 8) ? 4'b0010 : 4'b0000, 2'b00, 2'b11,
          mk(4'b1000, 4'b0010, H, 8'd90, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b0000, 4'b0000, H, 8'd90, 2'b00, 3'b000));

    // Dodged kick while p2 winds up a punch; p2 keeps attacking and lands next tick.
    add(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b11, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b0001, 2'b00, 2'b11, mk(4'b1001, 4'b0000, H, H, 2'b00, 3'b000));
    for (int k = 2; k <= 4; k++)
      add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b1001, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b01, 2'b11,
        mk(4'b1001, 4'b0001, H, H - Chip, {1'b0, Chip[0]}, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11,
        mk(4'b0001, 4'b1001, 8'd95, H - Chip, 2'b10, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11,
        mk(4'b0001, 4'b1001, 8'd95, H - Chip, 2'b00, 3'b000));

    // Trade: both kick on the same tick.
    add(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    add(1'b0, 1'b1, 4'b1010, 2'b00, 2'b11, mk(4'b1010, 4'b0000, H, H, 2'b00, 3'b000));
    for (int k = 1; k <= 4; k++)
      add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b1010, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b11, mk(4'b0000, 4'b1010, 8'd90, 8'd90, 2'b11, 3'b000));

    // Reset mid-windup with the request still held.
    add(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b11, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b11, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b1, 1'b0, 4'b1000, 2'b00, 2'b11, idle0);

    // Out of range: full 4+3+6 sequence, re-accept exactly on tick 14.
    add(1'b1, 1'b0, 4'b0000, 2'b00, 2'b01, idle0);
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b01, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    for (int k = 1; k <= 12; k++)
      add(1'b0, 1'b1, 4'b0000, 2'b00, 2'b01, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b01, idle0);
    add(1'b0, 1'b1, 4'b1000, 2'b00, 2'b01, mk(4'b1000, 4'b0000, H, H, 2'b00, 3'b000));

    foreach (tbl[i]) apply(tbl[i]);

    // KO: wear p2 down to 5 hp, then a punch finishes and the game freezes.
    step(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);
    hp2m = H;
    for (int n = 0; n < 9; n++) p1_attack(1'b1);
    p1_attack(1'b0);
    chk(row_id, "hp_before_ko", p2_hp, 8'd5);
    p1_attack(1'b0);
    repeat (3) step(1'b0, 1'b1, 4'b1111, 2'b00, 2'b11,
                    mk(4'b0000, 4'b0000, H, 8'd0, 2'b00, 3'b100));
    step(1'b1, 1'b0, 4'b0000, 2'b00, 2'b11, idle0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
